prog_feeder: RTL and testbench
==============================

PROG_FEEDER -- requirements
Module: prog_feeder

Interface
REQ-001 SHALL have parameter W, default 6: instruction/data word width, equal to the CPU DIN width.
REQ-002 SHALL have parameter DEPTH, default 16: number of program memory words, power of 2.
REQ-003 SHALL have parameter MVI_OP, default 2'b01: opcode value in word bits [W-1:W-2] that marks a move-immediate instruction.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port wr_en, input, 1: program-load strobe.
REQ-007 SHALL have port wr_addr, input, log2(DEPTH): program-load address.
REQ-008 SHALL have port wr_data, input, W: program-load word.
REQ-009 SHALL have port prog_len, input, log2(DEPTH)+1: program length in words, sampled on start.
REQ-010 SHALL have port start, input, 1: begin execution at address 0.
REQ-011 SHALL have port done, input, 1: CPU instruction-complete flag.
REQ-012 SHALL have port din, output, W: word driven to CPU DIN.
REQ-013 SHALL have port run, output, 1: CPU run request.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port pc, output, log2(DEPTH): current program address.
REQ-016 SHALL have port finished, output, 1: one-cycle pulse at program end.
REQ-017 SHALL have port error, output, 1: sticky timeout flag.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, END, ERR.
REQ-019 SHALL write wr_data to mem[wr_addr] on clk when wr_en=1 and state=IDLE, and SHALL ignore wr_en in all other states.
REQ-020 SHALL drive din=mem[pc] combinationally in every state.
REQ-021 IDLE: on start=1, SHALL latch prog_len to len_q, set pc=0, and go to END if prog_len=0, else to ISSUE.
REQ-022 ISSUE: SHALL assert run=1 for exactly one cycle, latch mem[pc][W-1:W-2] to op_q, increment pc, and go to WAIT.
REQ-023 WAIT: SHALL hold run=0 and pc, so that din presents the immediate word for move-immediate.
REQ-024 WAIT: on done=1, SHALL additionally increment pc if op_q=MVI_OP.
REQ-025 WAIT: on done=1, SHALL then go to END if the resulting pc is at or beyond len_q, else to ISSUE.
REQ-026 The pc comparison SHALL use log2(DEPTH)+1 bits so that len_q=DEPTH ends cleanly without wrap.
REQ-027 END: SHALL pulse finished=1 for one cycle and return to IDLE, with pc holding its final value.
REQ-028 SHALL ignore start while busy=1.
REQ-029 If done and start are both high in IDLE, start SHALL take effect and done SHALL be ignored.
REQ-030 SHALL advance by at most one pc step per WAIT exit, even if done is held high for several cycles.

Reset
REQ-031 On reset=1, asynchronously, SHALL set state=IDLE, pc=0, run=0, finished=0, error=0, len_q=0, op_q=0.
REQ-032 Program memory SHALL NOT be cleared by reset, and its contents SHALL survive a reset mid-program.
REQ-033 Reset asserted during ISSUE or WAIT SHALL abort the program, with no finished pulse.

Configuration
REQ-034 Macro FEEDER_TIMEOUT_EN SHALL control the WAIT timeout.
REQ-035 With FEEDER_TIMEOUT_EN defined: a 4-bit counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-036 With FEEDER_TIMEOUT_EN defined: reaching 15 without done SHALL set error=1 and go to ERR.
REQ-037 With FEEDER_TIMEOUT_EN defined: ERR SHALL hold busy=1 and run=0 until reset.
REQ-038 Without FEEDER_TIMEOUT_EN: WAIT SHALL wait indefinitely, error SHALL be tied 0, and ERR SHALL be unreachable.

Verification
REQ-039 Load mem[0]=6'b000110 (non-MVI), prog_len=1, start; done after 3 cycles -> one run pulse, din=6'b000110 during ISSUE, pc=1, finished pulse, busy=0.
REQ-040 Load mem[0]=6'b010000 (MVI), mem[1]=6'b000101, mem[2]=6'b100001, prog_len=3, start; done per instruction -> run pulses at pc=0 and pc=2 only, din=6'b000101 during first WAIT, finished after second done.
REQ-041 prog_len=0, start -> finished pulse on the cycle after IDLE exit, run never asserted.
REQ-042 prog_len=16, all words non-MVI, done each WAIT -> 16 run pulses, finished, pc=0 after 4-bit wrap, no extra issue.
REQ-043 Assert reset during WAIT of instruction 2 -> run=0, busy=0, pc=0 immediately; restart re-executes from the original memory contents.
REQ-044 FEEDER_TIMEOUT_EN defined, done held 0 -> error=1 after 15 WAIT cycles, busy stays 1, start ignored; reset clears error.

Source files
------------

// File: rtl/prog_feeder.sv
// prog_feeder: loads a small program memory, then feeds it word-by-word to a CPU DIN port.
// Optional WAIT timeout / ERR trap enabled by defining FEEDER_TIMEOUT_EN.
module prog_feeder #(
  parameter int         W      = 6,
  parameter int         DEPTH  = 16,
  parameter logic [1:0] MVI_OP = 2'b01,
  localparam int        AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          done,
  output logic [W-1:0]  din,
  output logic          run,
  output logic          busy,
  output logic [AW-1:0] pc,
  output logic          finished,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_END,
    S_ERR
  } state_t;

  logic [W-1:0] r_mem [DEPTH];

  state_t      r_state;
  state_t      w_state_nxt;
  // one extra bit so a full-depth program ends without wrapping
  logic [AW:0] r_pc;
  logic [AW:0] w_pc_nxt;
  logic [AW:0] r_len;
  logic [AW:0] w_len_nxt;
  logic [1:0]  r_op;
  logic [1:0]  w_op_nxt;
  logic [W-1:0] w_rd;
  logic         w_is_mvi;
  logic [AW:0]  w_pc_step;

`ifdef FEEDER_TIMEOUT_EN
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_err;
  logic       w_err_nxt;
`endif

  assign w_rd      = r_mem[r_pc[AW-1:0]];
  assign w_is_mvi  = (r_op == MVI_OP);
  assign w_pc_step = r_pc + {{AW{1'b0}}, w_is_mvi};

  assign din      = w_rd;
  assign pc       = r_pc[AW-1:0];
  assign run      = (r_state == S_ISSUE);
  assign busy     = (r_state != S_IDLE);
  assign finished = (r_state == S_END);

`ifdef FEEDER_TIMEOUT_EN
  assign error = r_err;
`else
  assign error = 1'b0;
`endif

  // program memory: loadable only while idle, never cleared by reset
  always_ff @(posedge clk) begin
    if (wr_en && (r_state == S_IDLE)) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // next-state and datapath updates for the sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_len_nxt   = r_len;
    w_op_nxt    = r_op;
`ifdef FEEDER_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_len_nxt   = prog_len;
          w_pc_nxt    = '0;
          w_state_nxt = (prog_len == '0) ? S_END : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_op_nxt    = w_rd[W-1 -: 2];
        w_pc_nxt    = r_pc + {{AW{1'b0}}, 1'b1};
        w_state_nxt = S_WAIT;
`ifdef FEEDER_TIMEOUT_EN
        w_cnt_nxt   = 4'd0;
`endif
      end
      S_WAIT: begin
        if (done) begin
          // skip over the immediate word of a move-immediate
          w_pc_nxt    = w_pc_step;
          w_state_nxt = (w_pc_step >= r_len) ? S_END : S_ISSUE;
        end
`ifdef FEEDER_TIMEOUT_EN
        else begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == 4'd14) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_ERR;
          end
        end
`endif
      end
      S_END: begin
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_len   <= '0;
      r_op    <= '0;
`ifdef FEEDER_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_len   <= w_len_nxt;
      r_op    <= w_op_nxt;
`ifdef FEEDER_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_prog_feeder.sv
// tb_prog_feeder: directed programs with a scoreboard of expected run/finished events.
// The timeout scenario is included when FEEDER_TIMEOUT_EN is defined.
module tb_prog_feeder;

  localparam int W     = 6;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          done;
  logic [W-1:0]  din;
  logic          run;
  logic          busy;
  logic [AW-1:0] pc;
  logic          finished;
  logic          error;

  always #5 clk = ~clk;

  prog_feeder #(
    .W(W),
    .DEPTH(DEPTH),
    .MVI_OP(2'b01)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .prog_len(prog_len),
    .start(start),
    .done(done),
    .din(din),
    .run(run),
    .busy(busy),
    .pc(pc),
    .finished(finished),
    .error(error)
  );

  typedef struct {
    bit fin;
    int pc;
    int din;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void exp_issue(input int p, input logic [W-1:0] d);
    ev_t e;
    e.fin = 1'b0;
    e.pc  = p;
    e.din = int'(d);
    q.push_back(e);
  endfunction

  function automatic void exp_fin(input int p);
    ev_t e;
    e.fin = 1'b1;
    e.pc  = p;
    e.din = 0;
    q.push_back(e);
  endfunction

  // monitor: every run or finished pulse must match the next expected event
  always @(negedge clk) begin
    ev_t e;
    if (reset === 1'b0 && (run === 1'b1 || finished === 1'b1)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: run=%0b finished=%0b pc=%0d din=%0d, none expected",
                 run, finished, pc, din);
      end else begin
        e = q.pop_front();
        chk("ev_kind_finished", 32'(finished), 32'(e.fin));
        chk("ev_pc", 32'(pc), e.pc);
        if (!e.fin) chk("ev_din", 32'(din), e.din);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // run a program, answering each issue with done after dly WAIT cycles
  task automatic exec(input int len, input int dly, input bit disturb,
                      input bit chk_wd, input logic [W-1:0] wd);
    int guard;
    bit first;
    guard = 0;
    first = 1'b1;
    prog_len = len[AW:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    while (busy === 1'b1 && guard < 500) begin
      if (run === 1'b1) begin
        tick();
        if (chk_wd && first) chk("wait_din", 32'(din), 32'(wd));
        first = 1'b0;
        for (int k = 0; k < dly; k++) begin
          if (disturb) begin
            start    = 1'b1;
            prog_len = '0;
            wr_en    = 1'b1;
            wr_addr  = 4'd2;
            wr_data  = '0;
          end
          tick();
        end
        start    = 1'b0;
        wr_en    = 1'b0;
        prog_len = len[AW:0];
        done     = 1'b1;
        tick();
        done     = 1'b0;
      end else begin
        tick();
      end
      guard++;
    end
    chk("exec_terminates", 32'(guard < 500), 32'd1);
    chk("busy_after_exec", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    prog_len = '0;
    start    = 1'b0;
    done     = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    reset = 1'b0;
    tick();

    // single non-MVI instruction, done after 3 WAIT cycles
    load(0, 6'b000110);
    exp_issue(0, 6'b000110);
    exp_fin(1);
    exec(1, 2, 1'b0, 1'b0, '0);
    chk("t1_pc", 32'(pc), 32'd1);

    // MVI then plain op; start/writes while busy must be ignored
    load(0, 6'b010000);
    load(1, 6'b000101);
    load(2, 6'b100001);
    exp_issue(0, 6'b010000);
    exp_issue(2, 6'b100001);
    exp_fin(3);
    exec(3, 3, 1'b1, 1'b1, 6'b000101);
    chk("t2_pc", 32'(pc), 32'd3);

    // zero-length program; done alongside start is ignored
    exp_fin(0);
    prog_len = '0;
    start    = 1'b1;
    done     = 1'b1;
    tick();
    start = 1'b0;
    done  = 1'b0;
    chk("t3_finished", 32'(finished), 32'd1);
    chk("t3_run", 32'(run), 32'd0);
    tick();
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_pc", 32'(pc), 32'd0);

    // full-depth program ends with pc wrapped to 0
    for (int i = 0; i < 16; i++) begin
      load(i, {2'b00, 4'(i)});
      exp_issue(i, {2'b00, 4'(i)});
    end
    exp_fin(0);
    exec(16, 0, 1'b0, 1'b0, '0);
    chk("t4_pc", 32'(pc), 32'd0);

    // done held high throughout: one pc step per WAIT exit
    load(0, 6'b010011);
    load(1, 6'b000111);
    load(2, 6'b110000);
    exp_issue(0, 6'b010011);
    exp_issue(2, 6'b110000);
    exp_fin(3);
    done     = 1'b1;
    prog_len = 5'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    done = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_pc", 32'(pc), 32'd3);

    // reset during WAIT of instruction 2, then rerun from retained memory
    load(0, 6'b100011);
    load(1, 6'b110100);
    load(2, 6'b001001);
    exp_issue(0, 6'b100011);
    exp_issue(1, 6'b110100);
    prog_len = 5'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("t6_run", 32'(run), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_pc", 32'(pc), 32'd0);
    chk("t6_finished", 32'(finished), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_queue_drained", 32'(q.size()), 32'd0);
    exp_issue(0, 6'b100011);
    exp_issue(1, 6'b110100);
    exp_issue(2, 6'b001001);
    exp_fin(3);
    exec(3, 1, 1'b0, 1'b0, '0);
    chk("t6_rerun_pc", 32'(pc), 32'd3);

`ifdef FEEDER_TIMEOUT_EN
    // no done: error after 15 WAIT cycles, stuck busy until reset
    load(0, 6'b000001);
    exp_issue(0, 6'b000001);
    prog_len = 5'd1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    chk("to_error_early", 32'(error), 32'd0);
    tick();
    chk("to_error_set", 32'(error), 32'd1);
    chk("to_busy", 32'(busy), 32'd1);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    chk("to_busy_hold", 32'(busy), 32'd1);
    chk("to_run_low", 32'(run), 32'd0);
    chk("to_error_sticky", 32'(error), 32'd1);
    reset = 1'b1;
    tick();
    chk("to_error_cleared", 32'(error), 32'd0);
    chk("to_busy_cleared", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
`endif

    tick();
    tick();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
